plane_spawner: RTL

- Downstream consumer of the difficulty controller: takes `plane_amount` (1..10) and `flying_rate` (0..3) and maintains the live plane table for the game.
- Once per video frame it advances every active plane leftward, frees planes that leave the screen, and spawns new planes up to the allowed amount at pseudo-random heights.
- The renderer reads plane positions through a random-access read port. Collision logic kills planes through a hit port.

---
 rtl/plane_spawner_pkg.sv | 36 +++
 rtl/plane_spawner_lfsr.sv | 30 +++
 rtl/plane_spawner.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/plane_spawner_pkg.sv
// Shared game constants, plane slot record and spawner FSM states.
// Latency: none (types and constants only).
// Backpressure: none.
package plane_spawner_pkg;

  localparam int MAX_PLANES = 10;
  localparam int IDX_W      = 4;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int SPRITE_H   = 8;
  // Highest legal top-row y plus one, so the sprite never crosses the bottom edge
  localparam int Y_SPAN     = SCREEN_H - SPRITE_H;

  typedef struct packed {
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SPAWN
  } state_t;

  // Fold a 7-bit random value into 0..Y_SPAN-1 with a single subtraction
  function automatic logic [Y_W-1:0] fold_y(input logic [6:0] r);
    if (r >= 7'(Y_SPAN)) begin
      return r - 7'(Y_SPAN);
    end
    return r;
  endfunction

endpackage

// File: rtl/plane_spawner_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) giving a spawn height folded into the screen.
// Latency: free-running, advances every cycle outside reset; o_y is combinational.
// Backpressure: none, the value is always available.
module plane_lfsr
  import plane_spawner_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  output logic [Y_W-1:0] o_y
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Shift every cycle; the seed must be nonzero or the register locks up
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  assign o_y = fold_y(r_lfsr[6:0]);

endmodule

// File: rtl/plane_spawner.sv
// Live plane table: per-frame move/escape scan over all slots, then one spawn decision.
// Latency: frame_tick to busy falling is MAX_PLANES+1 cycles; active_count lags table by 1.
// Backpressure: frame_tick while busy is dropped; hits are applied in every state.
module plane_spawner
  import plane_spawner_pkg::*;
#(
  parameter int         SPAWN_GAP = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_tick,
  input  logic [3:0]       plane_amount,
  input  logic [1:0]       flying_rate,
  input  logic             hit_valid,
  input  logic [IDX_W-1:0] hit_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_active,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic [3:0]       active_count,
  output logic             busy,
  output logic             escaped
);

  localparam int CNT_W = $clog2(SPAWN_GAP + 1);

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_limit;
  logic [2:0]            r_step;
  logic [CNT_W-1:0]      r_spawn_cnt;
  slot_t                 r_slots [MAX_PLANES];
  logic [3:0]            r_active_count;
  logic                  r_escaped;

  logic                  w_busy;
  logic                  w_do_move;
  logic                  w_do_spawn;
  logic                  w_start;
  logic [3:0]            w_limit;
  logic [3:0]            w_count;
  logic                  w_free_vld;
  logic [IDX_W-1:0]      w_free_idx;
  logic                  w_spawn_ok;
  logic [Y_W-1:0]        w_spawn_y;
  logic [MAX_PLANES-1:0] w_move_sel;
  logic [MAX_PLANES-1:0] w_hit_sel;
  logic                  w_escape;

  plane_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .o_y   (w_spawn_y)
  );

  assign w_start = (r_state == ST_IDLE) && frame_tick && enable;

  // Clamp the requested plane amount into 1..MAX_PLANES
  always_comb begin
    w_limit = plane_amount;
    if (plane_amount == 4'd0) begin
      w_limit = 4'd1;
    end else if (plane_amount > 4'(MAX_PLANES)) begin
      w_limit = 4'(MAX_PLANES);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: one slot per MOVE cycle, then a single SPAWN cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (frame_tick && enable) w_next = ST_MOVE;
      ST_MOVE:  if (r_idx == IDX_W'(MAX_PLANES - 1)) w_next = ST_SPAWN;
      ST_SPAWN: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    w_busy     = (r_state != ST_IDLE);
    w_do_move  = (r_state == ST_MOVE);
    w_do_spawn = (r_state == ST_SPAWN);
  end

  // Scan index plus frame parameters captured at the start of each update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_limit <= 4'd1;
      r_step  <= 3'd1;
    end else if (w_start) begin
      r_idx   <= '0;
      r_limit <= w_limit;
      r_step  <= {1'b0, flying_rate} + 3'd1;
    end else if (w_do_move) begin
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  // Occupancy count and lowest free slot, both from the live table
  always_comb begin
    w_count    = '0;
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = MAX_PLANES - 1; i >= 0; i--) begin
      w_count = w_count + {3'b000, r_slots[i].active};
      if (!r_slots[i].active) begin
        w_free_vld = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_spawn_ok = w_do_spawn && (r_spawn_cnt == '0) && (w_count < r_limit) && w_free_vld;

  // Per-slot move/hit selects; a hit on the slot being moved suppresses its escape
  always_comb begin
    w_move_sel = '0;
    w_hit_sel  = '0;
    w_escape   = 1'b0;
    for (int i = 0; i < MAX_PLANES; i++) begin
      w_move_sel[i] = w_do_move && (r_idx == IDX_W'(i));
      w_hit_sel[i]  = hit_valid && (hit_idx == IDX_W'(i)) && r_slots[i].active;
      if (w_move_sel[i] && r_slots[i].active && !w_hit_sel[i] &&
          (r_slots[i].x < X_W'(r_step))) begin
        w_escape = 1'b1;
      end
    end
  end

  // Slot table: spawn beats hit, hit beats move
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_PLANES; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_PLANES; i++) begin
        if (w_spawn_ok && (w_free_idx == IDX_W'(i))) begin
          r_slots[i] <= '{active: 1'b1, x: X_W'(SCREEN_W - 1), y: w_spawn_y};
        end else if (w_hit_sel[i]) begin
          r_slots[i] <= '0;
        end else if (w_move_sel[i] && r_slots[i].active) begin
          if (r_slots[i].x < X_W'(r_step)) begin
            r_slots[i] <= '0;
          end else begin
            r_slots[i].x <= r_slots[i].x - X_W'(r_step);
          end
        end
      end
    end
  end

  // Spawn pacing: reload after a spawn, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spawn_cnt <= '0;
    end else if (w_do_spawn) begin
      if (w_spawn_ok) begin
        r_spawn_cnt <= CNT_W'(SPAWN_GAP - 1);
      end else if (r_spawn_cnt != '0) begin
        r_spawn_cnt <= r_spawn_cnt - CNT_W'(1);
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active_count <= '0;
      r_escaped      <= 1'b0;
    end else begin
      r_active_count <= w_count;
      r_escaped      <= w_escape;
    end
  end

  // Renderer read port; out-of-range addresses read as an empty slot
  always_comb begin
    rd_active = 1'b0;
    rd_x      = '0;
    rd_y      = '0;
    for (int i = 0; i < MAX_PLANES; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_active = r_slots[i].active;
        rd_x      = r_slots[i].x;
        rd_y      = r_slots[i].y;
      end
    end
  end

  assign busy         = w_busy;
  assign escaped      = r_escaped;
  assign active_count = r_active_count;

endmodule
